dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 111 +++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned DEFAULT_LATENCY     = 2;
  localparam logic [31:0] ERR_RDATA           = 32'h0;

  // Misaligned byte address or word index beyond the array
  function automatic logic addr_is_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with combinational read and byte-enabled write
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Only the enabled byte lanes of the addressed word change
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder over a word array
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        accept;
  logic        commit;
  logic        addr_err;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign req_ready = (state_q == IDLE);
  assign accept    = (state_q == IDLE) && req_valid;
  assign commit    = (state_q == WAIT) && (cnt_q == 4'd0);
  assign addr_err  = addr_is_err(addr_q, DEPTH_WORDS);
  // rst gating keeps a pending store from landing on a reset edge
  assign mem_we    = commit && !rst && !addr_err && we_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (mem_rdata)
  );

  // State register; reset overrides any transition on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture at acceptance; later input changes are ignored
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Latency counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= ERR_RDATA;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= LAT_M1;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= addr_err;
        resp_rdata <= (addr_err || we_q) ? ERR_RDATA : mem_rdata;
      end else if ((state_q == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid1, req_ready1, req_we1;
  logic [31:0] req_addr1, req_wdata1;
  logic [3:0]  req_be1;
  logic        resp_valid1, resp_ready1, resp_err1;
  logic [31:0] resp_rdata1;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: error rule, byte-lane store, load of current word
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] er, output logic ee);
    int idx;
    idx = int'(addr >> 2);
    ee  = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    er  = 32'h0;
    if (!ee) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        er = model[idx];
      end
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold);
    logic [31:0] er;
    logic        ee;
    int          n;
    model_access(we, addr, wdata, be, er, ee);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    chk({tag, ".ready_pre"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk({tag, ".ready_post"}, 32'(req_ready), 32'd0);
    // Junk store to word 4 kept valid: must never be accepted or captured
    req_we = 1'b1; req_addr = 32'h10; req_wdata = $urandom; req_be = 4'hf;
    n = 0;
    while (n < 20) begin
      @(posedge clk); n++; #1;
      if (resp_valid) break;
    end
    chk({tag, ".latency"}, 32'(n), 32'(LAT));
    chk({tag, ".rdata"}, resp_rdata, er);
    chk({tag, ".err"}, 32'(resp_err), 32'(ee));
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, resp_rdata, er);
      chk({tag, ".hold_err"}, 32'(resp_err), 32'(ee));
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".release_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".release_ready"}, 32'(req_ready), 32'd1);
    resp_ready = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    int idx, acc_n;
    int acc [4];
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b0;
    req_valid1 = 1'b0; req_we1 = 1'b1; req_addr1 = '0; req_wdata1 = 32'hFFFF_FFFF;
    req_be1 = 4'h0; resp_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", 32'(resp_valid), 32'd0);
    chk("reset.rdata", resp_rdata, 32'd0);
    chk("reset.err", 32'(resp_err), 32'd0);
    chk("reset.ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    // Preload a working set through full-word stores
    for (int w = 0; w < 20; w++) begin
      idx = (w < 16) ? w : 1004 + w;
      txn("preload", 1'b1, 32'(idx * 4), $urandom, 4'hf, 0);
    end
    txn("pre_m4", 1'b1, 32'h10, 32'hDEADBEEF, 4'hf, 0);
    txn("pre_m8", 1'b1, 32'h20, 32'hAABBCCDD, 4'hf, 0);
    txn("pre_m2", 1'b1, 32'h08, 32'h0BADF00D, 4'hf, 0);

    txn("load_0x10", 1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("load_0x10.model", model[4], 32'hDEADBEEF);
    txn("store_0x20", 1'b1, 32'h20, 32'h11223344, 4'b0101, 0);
    txn("load_0x20", 1'b0, 32'h20, 32'h0, 4'h0, 0);
    chk("load_0x20.model", model[8], 32'hAA22CC44);
    txn("load_0x13", 1'b0, 32'h13, 32'h0, 4'h0, 0);
    txn("load_0x1000", 1'b0, 32'h1000, 32'h0, 4'h0, 0);
    txn("store_0x11", 1'b1, 32'h11, 32'h12345678, 4'hf, 0);
    txn("store_0x1000", 1'b1, 32'h1000, 32'h12345678, 4'hf, 0);
    txn("reload_0x10", 1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn("store_be0", 1'b1, 32'h20, 32'h55555555, 4'h0, 0);
    txn("load_after_be0", 1'b0, 32'h20, 32'h0, 4'h0, 0);
    txn("last_word", 1'b0, 32'hFFC, 32'h0, 4'h0, 0);
    txn("hold5", 1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Reset while a store is waiting to commit
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hFFFFFFFF; req_be = 4'hf;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait.valid", 32'(resp_valid), 32'd0);
    chk("rst_wait.rdata", resp_rdata, 32'd0);
    chk("rst_wait.err", 32'(resp_err), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait.ready_after", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait.no_ghost", 32'(resp_valid), 32'd0);
    txn("rst_wait.mem2", 1'b0, 32'h8, 32'h0, 4'h0, 0);
    chk("rst_wait.model", model[2], 32'h0BADF00D);

    // Reset while a response is held
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    chk("rst_resp.valid_pre", 32'(resp_valid), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_resp.valid", 32'(resp_valid), 32'd0);
    chk("rst_resp.ready", 32'(req_ready), 32'd1);

    // Reset wins over a same-edge acceptance
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'hf;
    req_wdata = 32'h0;
    @(posedge clk); #1;
    chk("rst_accept.ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_accept.no_resp", 32'(resp_valid), 32'd0);
    txn("rst_accept.mem4", 1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Randomized traffic over the working set plus error addresses
    for (int t = 0; t < 40; t++) begin
      idx = $urandom_range(0, 19);
      idx = (idx < 16) ? idx : 1004 + idx;
      a = 32'(idx * 4);
      case ($urandom_range(0, 9))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
        2: a = $urandom | 32'h8000_0000;
        default: ;
      endcase
      d = $urandom;
      txn("rand", 1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)),
          int'($urandom_range(0, 3)));
    end

    // LATENCY=1: back-to-back requests with resp_ready tied high
    acc_n = 0;
    @(negedge clk); req_valid1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (acc_n < 4 && req_ready1) begin
        acc[acc_n] = c;
        acc_n++;
      end
      if (resp_valid1) begin
        chk("lat1.rdata", resp_rdata1, 32'd0);
        chk("lat1.err", 32'(resp_err1), 32'd0);
      end
      @(negedge clk);
    end
    req_valid1 = 1'b0;
    chk("lat1.count", 32'(acc_n), 32'd4);
    for (int k = 1; k < 4; k++) chk("lat1.spacing", 32'(acc[k] - acc[k-1]), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
